// File: rtl/hs_burst_link.sv
// Burst req/ack link: a master FSM streams BURST_LEN incrementing words to a slave FSM over a
// registered four-phase handshake. The slave delays its ack, captures each word and keeps a count and checksum.
module hs_burst_link #(
  parameter  int unsigned DATA_W    = 8,
  parameter  int unsigned BURST_LEN = 4,
  parameter  int unsigned ACK_DELAY = 0,
  localparam int unsigned CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] base_data,
  output logic              busy,
  output logic              done,
  output logic              req,
  output logic              ack,
  output logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] last_word,
  output logic [CNT_W-1:0]  word_count,
  output logic [DATA_W-1:0] checksum
);

  localparam int unsigned IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned DLY_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = (ACK_DELAY > 0) ? DLY_W'(ACK_DELAY - 1) : '0;

  typedef enum logic [1:0] {M_IDLE, M_REQ, M_WAIT, M_DONE} m_state_e;
  typedef enum logic [1:0] {S_IDLE, S_DLY, S_ACK} s_state_e;

  m_state_e          m_state_q, m_state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;

  s_state_e          s_state_q, s_state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] ck_q, ck_d;
  logic              capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state_q <= M_IDLE;
      idx_q     <= '0;
      req_q     <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      m_state_q <= m_state_d;
      idx_q     <= idx_d;
      req_q     <= req_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    m_state_d = m_state_q;
    idx_d     = idx_q;
    req_d     = req_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    accept    = 1'b0;
    case (m_state_q)
      M_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          accept    = 1'b1;
          idx_d     = '0;
          data_d    = base_data;
          req_d     = 1'b1;
          busy_d    = 1'b1;
          m_state_d = M_REQ;
        end
      end
      M_REQ: begin
        if (ack_q) begin
          req_d     = 1'b0;
          m_state_d = M_WAIT;
        end
      end
      M_WAIT: begin
        if (!ack_q) begin
          if (idx_q != LAST_IDX) begin
            // Next word is the running data register plus one, so base_data need not be kept.
            idx_d     = idx_q + IDX_W'(1);
            data_d    = data_q + DATA_W'(1);
            req_d     = 1'b1;
            m_state_d = M_REQ;
          end else begin
            done_d    = 1'b1;
            m_state_d = M_DONE;
          end
        end
      end
      M_DONE: begin
        busy_d    = 1'b0;
        m_state_d = M_IDLE;
      end
      default: m_state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_state_q <= S_IDLE;
      dly_q     <= '0;
      ack_q     <= 1'b0;
      last_q    <= '0;
      cnt_q     <= '0;
      ck_q      <= '0;
    end else begin
      s_state_q <= s_state_d;
      dly_q     <= dly_d;
      ack_q     <= ack_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      ck_q      <= ck_d;
    end
  end

  always_comb begin
    s_state_d = s_state_q;
    dly_d     = dly_q;
    ack_d     = ack_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    ck_d      = ck_q;
    capture   = 1'b0;
    // Acceptance only happens with the master idle, so it never collides with a capture.
    if (accept) begin
      cnt_d = '0;
      ck_d  = '0;
    end
    case (s_state_q)
      S_IDLE: begin
        ack_d = 1'b0;
        if (req_q) begin
          if (ACK_DELAY == 0) begin
            capture = 1'b1;
          end else begin
            dly_d     = '0;
            s_state_d = S_DLY;
          end
        end
      end
      S_DLY: begin
        if (dly_q == DLY_LAST) capture = 1'b1;
        else                   dly_d   = dly_q + DLY_W'(1);
      end
      S_ACK: begin
        if (!req_q) begin
          ack_d     = 1'b0;
          s_state_d = S_IDLE;
        end
      end
      default: s_state_d = S_IDLE;
    endcase
    if (capture) begin
      ack_d     = 1'b1;
      last_d    = data_q;
      cnt_d     = cnt_q + CNT_W'(1);
      ck_d      = ck_q ^ data_q;
      s_state_d = S_ACK;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign req        = req_q;
  assign ack        = ack_q;
  assign data       = data_q;
  assign last_word  = last_q;
  assign word_count = cnt_q;
  assign checksum   = ck_q;

endmodule

// File: tb/tb_hs_burst_link.sv
// Directed bench for hs_burst_link: an ACK_DELAY=0 and an ACK_DELAY=2 instance run table-driven bursts
// plus hand-written held-start and mid-burst reset sequences.
module tb_hs_burst_link;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [7:0] base0, base1;
  logic       busy0, done0, req0, ack0, busy1, done1, req1, ack1;
  logic [7:0] data0, last0, ck0, data1, last1, ck1;
  logic [2:0] wc0, wc1;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  hs_burst_link #(.DATA_W(8), .BURST_LEN(4), .ACK_DELAY(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .base_data(base0), .busy(busy0), .done(done0),
    .req(req0), .ack(ack0), .data(data0), .last_word(last0), .word_count(wc0), .checksum(ck0)
  );

  hs_burst_link #(.DATA_W(8), .BURST_LEN(4), .ACK_DELAY(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .base_data(base1), .busy(busy1), .done(done1),
    .req(req1), .ack(ack1), .data(data1), .last_word(last1), .word_count(wc1), .checksum(ck1)
  );

  typedef struct packed {
    logic       busy, done, req, ack;
    logic [7:0] data, last;
    logic [2:0] wc;
    logic [7:0] ck;
  } obs_t;

  typedef struct {
    bit         sel;
    logic [7:0] base;
    logic [7:0] exp_last;
    logic [2:0] exp_wc;
    logic [7:0] exp_ck;
    int unsigned exp_done;
  } vec_t;

  function automatic obs_t obs(input bit sel);
    obs_t o;
    if (sel) o = '{busy1, done1, req1, ack1, data1, last1, wc1, ck1};
    else     o = '{busy0, done0, req0, ack0, data0, last0, wc0, ck0};
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic s, input logic [7:0] b);
    if (sel) begin start1 = s; base1 = b; end
    else     begin start0 = s; base0 = b; end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one burst from IDLE and checks word sequence, ack latency, done edge and final results.
  task automatic run_burst(input vec_t v);
    obs_t        o, prev;
    int unsigned d, ed, rise, widx, done_at;
    logic [7:0]  w;
    d = v.sel ? 2 : 0;
    drive(v.sel, 1'b1, v.base);
    @(posedge clk);
    @(negedge clk);
    drive(v.sel, 1'b0, ~v.base);
    o = obs(v.sel);
    chk("accept_busy", o.busy, 1);
    chk("accept_req", o.req, 1);
    chk("accept_data", o.data, v.base);
    chk("accept_wc_clear", o.wc, 0);
    chk("accept_ck_clear", o.ck, 0);
    chk("accept_ack", o.ack, 0);
    ed = 0; rise = 0; widx = 1; done_at = 0; prev = o;
    while (done_at == 0 && ed < 200) begin
      cyc();
      ed++;
      o = obs(v.sel);
      if (o.req && !prev.req) begin
        w = v.base + 8'(widx);
        chk("word_data", o.data, w);
        widx++;
        rise = ed;
      end
      if (o.ack && !prev.ack) chk("ack_latency", ed - rise, 1 + d);
      chk("req_ack_same_edge", {o.req ^ prev.req, o.ack ^ prev.ack} == 2'b11, 0);
      if (o.data != prev.data) chk("data_while_req", prev.req, 0);
      if (o.done) done_at = ed;
      prev = o;
    end
    chk("done_edge", done_at, v.exp_done);
    chk("done_busy", o.busy, 1);
    chk("done_last", o.last, v.exp_last);
    chk("done_wc", o.wc, v.exp_wc);
    chk("done_ck", o.ck, v.exp_ck);
    cyc();
    o = obs(v.sel);
    chk("post_done", o.done, 0);
    chk("post_busy", o.busy, 0);
    chk("hold_last", o.last, v.exp_last);
    chk("hold_wc", o.wc, v.exp_wc);
    chk("hold_ck", o.ck, v.exp_ck);
  endtask

  initial begin
    vec_t        vecs[6];
    obs_t        o;
    int unsigned ndone, ed;

    vecs[0] = '{sel: 1'b0, base: 8'hA5, exp_last: 8'hA8, exp_wc: 3'd4, exp_ck: 8'h0C, exp_done: 16};
    vecs[1] = '{sel: 1'b0, base: 8'hFE, exp_last: 8'h01, exp_wc: 3'd4, exp_ck: 8'h00, exp_done: 16};
    vecs[2] = '{sel: 1'b1, base: 8'h10, exp_last: 8'h13, exp_wc: 3'd4, exp_ck: 8'h00, exp_done: 24};
    vecs[3] = '{sel: 1'b0, base: 8'h00, exp_last: 8'h03, exp_wc: 3'd4, exp_ck: 8'h00, exp_done: 16};
    vecs[4] = '{sel: 1'b1, base: 8'h7F, exp_last: 8'h82, exp_wc: 3'd4, exp_ck: 8'hFC, exp_done: 24};
    vecs[5] = '{sel: 1'b0, base: 8'h33, exp_last: 8'h36, exp_wc: 3'd4, exp_ck: 8'h04, exp_done: 16};

    rst = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk("reset_dut0", obs(0), 0);
    chk("reset_dut1", obs(1), 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_dut0", obs(0), 0);
      chk("idle_dut1", obs(1), 0);
    end

    for (int i = 0; i < 6; i++) begin
      run_burst(vecs[i]);
      repeat (2) cyc();
    end

    // start held through the done cycle: one burst, then a fresh one on the edge after done falls.
    drive(0, 1'b1, 8'h60);
    @(posedge clk);
    @(negedge clk);
    ndone = 0;
    for (int e = 1; e <= 18; e++) begin
      cyc();
      o = obs(0);
      if (o.done) ndone++;
      if (e == 10) base0 = 8'h20;
      if (e == 16) chk("held_last", o.last, 8'h63);
      if (e == 17) chk("held_busy_e17", o.busy, 0);
      if (e == 18) begin
        chk("held_busy_e18", o.busy, 1);
        chk("held_req_e18", o.req, 1);
        chk("held_data_e18", o.data, 8'h20);
      end
    end
    chk("held_done_count", ndone, 1);
    start0 = 1'b0;
    ndone = 0;
    ed = 0;
    while (ndone == 0 && ed < 40) begin
      cyc();
      ed++;
      if (done0) ndone++;
    end
    chk("held_second_done_edge", ed, 16);
    chk("held_second_last", last0, 8'h23);
    chk("held_second_ck", ck0, 8'h00);
    repeat (3) cyc();

    // Reset during the second word's handshake.
    drive(0, 1'b1, 8'h40);
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) cyc();
    chk("mid_ack_word2", ack0, 1);
    chk("mid_wc_word2", wc0, 2);
    chk("mid_last_word2", last0, 8'h41);
    rst = 1'b0;
    #1;
    chk("mid_reset_async", obs(0), 0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("mid_reset_hold", obs(0), 0);
    end
    rst = 1'b1;
    cyc();
    chk("mid_release_idle", obs(0), 0);
    run_burst('{sel: 1'b0, base: 8'h50, exp_last: 8'h53, exp_wc: 3'd4, exp_ck: 8'h00, exp_done: 16});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
